mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DW, default 32: data word width, equal to the shared `WORD width.
REQ-002 Parameter AW, default 16: word address width, covering 65536 words.
REQ-003 Parameter STARVE_LIMIT, default 4: consecutive lost cycles after which the I-port is forced (see REQ-020).
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset; synchronous and active-low.
REQ-006 i_req  in  1  instruction-fetch read request.
REQ-007 i_addr  in  AW  fetch address; held stable while i_req is high and i_gnt is low.
REQ-008 i_gnt  out  1  fetch request accepted this cycle.
REQ-009 i_rvalid  out  1  i_rdata valid.
REQ-010 i_rdata  out  DW  fetch data.
REQ-011 d_req  in  1  data-port request.
REQ-012 d_we  in  1  data-port write enable.
REQ-013 d_addr  in  AW  data-port address; held with d_req until d_gnt.
REQ-014 d_wdata  in  DW  data-port write data; held with d_req until d_gnt.
REQ-015 d_gnt  out  1  data-port request accepted this cycle.
REQ-016 d_rvalid  out  1  d_rdata valid (reads only).
REQ-017 d_rdata  out  DW  data-port read data.
REQ-018 m_en, m_we, m_addr, m_wdata  out  1/1/AW/DW  single-port synchronous memory command.
REQ-019 m_rdata  in  DW  memory read data, valid the cycle after an m_en=1, m_we=0 command.

Function
REQ-020 Grant rule, applied each cycle:
- only one of i_req/d_req high: that port is granted;
- both high: D-port wins, except the I-port wins when starve_cnt == STARVE_LIMIT.
REQ-021 i_gnt and d_gnt are combinational from the requests and registered state, one-hot or zero; the winner's command drives m_* in the same cycle, with m_en=1.
REQ-022 No grant: m_en=0, m_we=0; m_addr and m_wdata hold their last values.
REQ-023 Read latency is exactly 1: a read granted in cycle N asserts <port>_rvalid in cycle N+1 with <port>_rdata = m_rdata; an owner flag registered in cycle N routes it.
REQ-024 Back-to-back grants are allowed every cycle; throughput is one access per cycle; no bubbles are inserted.
REQ-025 A write raises no rvalid; write data is in memory for a read granted in the next cycle.
REQ-026 When not valid, both rdata outputs hold their last value and rvalid is 0.
REQ-027 starve_cnt: increments when i_req=1 and d_gnt=1; clears when i_gnt=1 or i_req=0; saturates at STARVE_LIMIT.
REQ-028 Read FSM states: IDLE (no read outstanding), RD_I, RD_D (read outstanding for that port).
- Next state is chosen each cycle from the current grant, so RD_I -> RD_D directly is legal.

Reset
REQ-029 With rst=0 at a rising edge: state=IDLE, starve_cnt=0, all gnt/rvalid=0, m_en=0, m_we=0, m_addr=0, m_wdata=0, i_rdata=0, d_rdata=0.
REQ-030 Reset asserted while a read is outstanding discards that read; no rvalid appears after reset release.
REQ-031 While rst=0, grants are forced low regardless of requests.

Configuration
REQ-032 Macro MEM_ARB_STARVE_GUARD_EN defined: REQ-020 forcing and REQ-027 counter are present.
REQ-033 Macro undefined: pure fixed D-priority, no starve_cnt logic; STARVE_LIMIT is ignored.

Structure
REQ-034 A shared package holds the FSM state encoding (IDLE/RD_I/RD_D), the port-ID constants (PORT_I=0, PORT_D=1) and the default DW/AW values.
REQ-035 One sub-module, mem_arb_pick: pure grant-decision logic taking the requests and starve status and returning the one-hot grant.
REQ-036 Registers and the FSM stay in mem_arbiter.

Verification
REQ-037 Bench models a 65536-word synchronous memory.
REQ-038 I-only read: i_req=1, i_addr=0x0010, mem[0x0010]=0xDEADBEEF -> i_gnt same cycle; next cycle i_rvalid=1, i_rdata=0xDEADBEEF.
REQ-039 Write then read: D write 0x1234 -> addr 0x0020, then D read 0x0020 -> d_rvalid one cycle after the read grant, d_rdata=0x00001234, i_rvalid=0 throughout.
REQ-040 Contention: i_req and d_req held high with macro on and STARVE_LIMIT=4 -> d_gnt for 4 cycles, i_gnt on the 5th; repeats.
- With the macro off -> i_gnt never asserts.
REQ-041 Alternating reads: I at 0x0001 in cycle N, D at 0x0002 in cycle N+1 -> i_rvalid at N+1, d_rvalid at N+2, with correct data each.
REQ-042 Reset mid-read: read granted in cycle N, rst=0 at edge N+1 -> i_rvalid and d_rvalid remain 0, and state=IDLE after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: read FSM encoding,
// port identifiers and default bus widths.
package mem_arbiter_pkg;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 16;

  localparam int PORT_I = 0;
  localparam int PORT_D = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD_I = 2'd1,
    ST_RD_D = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction port, data port and memory command signals.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) ();

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Grant decision: D-port has priority unless the I-port is starved.
// Output is one-hot (indexed by PORT_I/PORT_D) or zero when disabled.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       en_i,
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  logic       starve_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (en_i) begin
      if (i_req_i && (!d_req_i || starve_i)) begin
        gnt_o[PORT_I] = 1'b1;
      end else if (d_req_i) begin
        gnt_o[PORT_D] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-port synchronous memory.
// Optional I-port anti-starvation forcing is enabled by MEM_ARB_STARVE_GUARD_EN.
//
//   state   | meaning
//   ST_IDLE | no read outstanding
//   ST_RD_I | fetch read outstanding, data returns this cycle
//   ST_RD_D | data-port read outstanding, data returns this cycle
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DW           = DEF_DW,
  parameter int AW           = DEF_AW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  logic [1:0]    gnt;
  logic          starve;
  state_e        state_q, state_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] i_rdata_q, d_rdata_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  assign starve = (starve_cnt_q == SW'(STARVE_LIMIT));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (gnt[PORT_I] || !bus.i_req) begin
      starve_cnt_d = '0;
    end else if (gnt[PORT_D] && !starve) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) starve_cnt_q <= '0;
    else      starve_cnt_q <= starve_cnt_d;
  end
`else
  // Fixed D-priority build: the limit has no effect.
  logic unused_limit;
  assign unused_limit = (STARVE_LIMIT != 0);
  assign starve       = 1'b0;
`endif

  mem_arb_pick u_pick (
    .en_i     (rst),
    .i_req_i  (bus.i_req),
    .d_req_i  (bus.d_req),
    .starve_i (starve),
    .gnt_o    (gnt)
  );

  assign bus.i_gnt = gnt[PORT_I];
  assign bus.d_gnt = gnt[PORT_D];
  assign bus.m_en  = |gnt;
  assign bus.m_we  = gnt[PORT_D] & bus.d_we;

  // Address/data follow the winner; they hold the last command when idle.
  always_comb begin
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    if (gnt[PORT_D]) begin
      m_addr_d  = bus.d_addr;
      m_wdata_d = bus.d_wdata;
    end else if (gnt[PORT_I]) begin
      m_addr_d  = bus.i_addr;
    end
  end

  assign bus.m_addr  = m_addr_d;
  assign bus.m_wdata = m_wdata_d;

  always_comb begin
    state_d = ST_IDLE;
    if (gnt[PORT_I]) begin
      state_d = ST_RD_I;
    end else if (gnt[PORT_D] && !bus.d_we) begin
      state_d = ST_RD_D;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      if (state_q == ST_RD_I) i_rdata_q <= bus.m_rdata;
      if (state_q == ST_RD_D) d_rdata_q <= bus.m_rdata;
    end
  end

  // Returned data passes straight through; the held copy covers idle cycles.
  assign bus.i_rvalid = (state_q == ST_RD_I);
  assign bus.d_rvalid = (state_q == ST_RD_D);
  assign bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : i_rdata_q;
  assign bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic against a behavioural model of grants, memory contents and read returns.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  mem_arbiter #(.DW(DW), .AW(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a, ~a};
  endfunction

  // Synchronous 65536-word memory seen by the DUT.
  logic [DW-1:0] mem    [0:65535];
  bit            mem_wr [0:65535];
  logic [DW-1:0] mem_rd_q = '0;

  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) begin
        mem[bus.m_addr]    <= bus.m_wdata;
        mem_wr[bus.m_addr] <= 1'b1;
      end else begin
        mem_rd_q <= mem_wr[bus.m_addr] ? mem[bus.m_addr] : init_val(bus.m_addr);
      end
    end
  end
  assign bus.m_rdata = mem_rd_q;

  // Reference model state.
  logic [DW-1:0] ref_mem [int];
  int            n_pass = 0;
  int            n_chk  = 0;
  int            lost   = 0;
  int            pend_port = -1;
  logic [DW-1:0] pend_data = '0;
  logic [DW-1:0] hold_i = '0, hold_d = '0;
  logic [AW-1:0] hold_addr = '0;

  logic          o_i_gnt, o_d_gnt, o_i_rv, o_d_rv;
  logic [DW-1:0] o_i_rd, o_d_rd;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock cycle: inputs are already driven; compare at the falling edge.
  task automatic step(input bit rst_at_edge);
    int win;
    bit rst_edge;
    @(negedge clk);
    o_i_gnt = bus.i_gnt;
    o_d_gnt = bus.d_gnt;
    o_i_rv  = bus.i_rvalid;
    o_d_rv  = bus.d_rvalid;
    o_i_rd  = bus.i_rdata;
    o_d_rd  = bus.d_rdata;

    if (pend_port == PORT_I) hold_i = pend_data;
    if (pend_port == PORT_D) hold_d = pend_data;
    check("i_rvalid", 64'(o_i_rv), 64'(pend_port == PORT_I));
    check("d_rvalid", 64'(o_d_rv), 64'(pend_port == PORT_D));
    check("i_rdata", 64'(o_i_rd), 64'(hold_i));
    check("d_rdata", 64'(o_d_rd), 64'(hold_d));

    win = -1;
    if (rst) begin
      if (bus.i_req && bus.d_req) win = (GUARD && lost == LIMIT) ? PORT_I : PORT_D;
      else if (bus.d_req)         win = PORT_D;
      else if (bus.i_req)         win = PORT_I;
    end
    check("i_gnt", 64'(o_i_gnt), 64'(win == PORT_I));
    check("d_gnt", 64'(o_d_gnt), 64'(win == PORT_D));
    check("m_en", 64'(bus.m_en), 64'(win >= 0));
    check("m_we", 64'(bus.m_we), 64'(win == PORT_D && bus.d_we));
    if (win == PORT_I)      hold_addr = bus.i_addr;
    else if (win == PORT_D) hold_addr = bus.d_addr;
    check("m_addr", 64'(bus.m_addr), 64'(hold_addr));
    if (win == PORT_D && bus.d_we) check("m_wdata", 64'(bus.m_wdata), 64'(bus.d_wdata));

    pend_port = -1;
    if (win == PORT_I) begin
      pend_port = PORT_I;
      pend_data = ref_rd(bus.i_addr);
    end else if (win == PORT_D) begin
      if (bus.d_we) ref_mem[int'(bus.d_addr)] = bus.d_wdata;
      else begin
        pend_port = PORT_D;
        pend_data = ref_rd(bus.d_addr);
      end
    end
    if (win == PORT_D && bus.i_req) lost = (lost < LIMIT) ? lost + 1 : LIMIT;
    else                            lost = 0;

    rst_edge = !rst || rst_at_edge;
    if (rst_at_edge) rst = 1'b0;
    if (rst_edge) begin
      pend_port = -1;
      lost      = 0;
      hold_i    = '0;
      hold_d    = '0;
      hold_addr = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic d_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    step(1'b0);
    bus.d_req   = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    bus.i_req   = 1'b1;
    bus.i_addr  = 16'h0007;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0009;
    bus.d_wdata = 32'h1111_2222;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_i_gnt", 64'(bus.i_gnt), 64'd0);
    check("rst_d_gnt", 64'(bus.d_gnt), 64'd0);
    check("rst_m_en", 64'(bus.m_en), 64'd0);
    check("rst_m_we", 64'(bus.m_we), 64'd0);
    check("rst_m_addr", 64'(bus.m_addr), 64'd0);
    check("rst_m_wdata", 64'(bus.m_wdata), 64'd0);
    check("rst_i_rvalid", 64'(bus.i_rvalid), 64'd0);
    check("rst_d_rvalid", 64'(bus.d_rvalid), 64'd0);
    check("rst_i_rdata", 64'(bus.i_rdata), 64'd0);
    check("rst_d_rdata", 64'(bus.d_rdata), 64'd0);
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    rst       = 1'b1;

    // Preload through the data port.
    d_access(1'b1, 16'h0010, 32'hDEAD_BEEF);
    d_access(1'b1, 16'h0001, 32'hA5A5_0001);
    d_access(1'b1, 16'h0002, 32'h5A5A_0002);

    // Single fetch read.
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0010;
    step(1'b0);
    check("fetch_gnt", 64'(o_i_gnt), 64'd1);
    bus.i_req = 1'b0;
    step(1'b0);
    check("fetch_rvalid", 64'(o_i_rv), 64'd1);
    check("fetch_rdata", 64'(o_i_rd), 64'hDEAD_BEEF);

    // Write then read back on the data port.
    d_access(1'b1, 16'h0020, 32'h0000_1234);
    check("wr_no_rvalid", 64'(o_d_rv), 64'd0);
    d_access(1'b0, 16'h0020, 32'h0);
    check("rd_gnt", 64'(o_d_gnt), 64'd1);
    check("rd_no_early_rvalid", 64'(o_d_rv), 64'd0);
    step(1'b0);
    check("rd_rvalid", 64'(o_d_rv), 64'd1);
    check("rd_rdata", 64'(o_d_rd), 64'h0000_1234);
    check("rd_i_quiet", 64'(o_i_rv), 64'd0);

    // Sustained contention: starvation pattern.
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0005;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0006;
    for (int k = 0; k < 15; k++) begin
      step(1'b0);
      check("contend_i_gnt", 64'(o_i_gnt), 64'(GUARD && (k % 5) == 4));
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    step(1'b0);

    // Alternating ports on consecutive cycles.
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0001;
    step(1'b0);
    bus.i_req  = 1'b0;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0002;
    step(1'b0);
    check("alt_i_rvalid", 64'(o_i_rv), 64'd1);
    check("alt_i_rdata", 64'(o_i_rd), 64'hA5A5_0001);
    bus.d_req = 1'b0;
    step(1'b0);
    check("alt_d_rvalid", 64'(o_d_rv), 64'd1);
    check("alt_d_rdata", 64'(o_d_rd), 64'h5A5A_0002);
    check("alt_i_done", 64'(o_i_rv), 64'd0);

    // Reset landing on the edge after a read grant.
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0003;
    step(1'b1);
    check("rstmid_gnt", 64'(o_i_gnt), 64'd1);
    step(1'b0);
    check("rstmid_forced_gnt", 64'(o_i_gnt), 64'd0);
    check("rstmid_i_rvalid", 64'(o_i_rv), 64'd0);
    check("rstmid_d_rvalid", 64'(o_d_rv), 64'd0);
    bus.i_req = 1'b0;
    rst       = 1'b1;
    step(1'b0);
    check("rstrel_i_rvalid", 64'(o_i_rv), 64'd0);
    check("rstrel_d_rvalid", 64'(o_d_rv), 64'd0);
    step(1'b0);
    check("rstrel_idle", 64'(o_i_rv | o_d_rv), 64'd0);

    // Randomized traffic honouring the hold-until-grant rules.
    for (int c = 0; c < 800; c++) begin
      if (!bus.i_req || o_i_gnt) begin
        bus.i_req  = ($urandom_range(0, 3) != 0);
        bus.i_addr = AW'($urandom_range(0, 31));
      end
      if (!bus.d_req || o_d_gnt) begin
        bus.d_req   = ($urandom_range(0, 2) != 0);
        bus.d_we    = $urandom_range(0, 1) != 0;
        bus.d_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
        bus.d_wdata = $urandom;
      end
      step(1'b0);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    step(1'b0);
    step(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
